product_accumulator: RTL and testbench

Sequential stage directly downstream of the 8-bit combinational multiplier. It consumes the 16-bit product stream through a valid/ready handshake and sums each group of N products. Each finished sum is presented as a held result with its own valid/ready handshake. The multiplier stays purely combinational; this block adds all registering and flow control on its output.

---
 rtl/product_accumulator.sv | 136 +++++++++++++
 tb/tb_product_accumulator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums each group of N unsigned 16-bit products from the
// multiplier stream and presents every finished sum as a held, saturating
// result with its own valid/ready handshake.
module product_accumulator #(
    parameter int unsigned N     = 8,
    parameter int unsigned ACC_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      product,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);

    localparam int unsigned PROD_W = 16;
    localparam int unsigned CNT_W  = $clog2(N);
    // Sum width is wide enough for max(acc) + max(product) without wrapping.
    localparam int unsigned SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W:0]     r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sticky;
    logic [ACC_W-1:0]   r_acc_out;
    logic               r_overflow;
    logic               r_out_valid;

    state_t             w_state_nxt;
    logic [ACC_W:0]     w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_sticky_nxt;
    logic [ACC_W-1:0]   w_acc_out_nxt;
    logic               w_overflow_nxt;
    logic               w_out_valid_nxt;

    logic               w_accept;
    logic [SUM_W-1:0]   w_sum;
    logic               w_sat;
    logic [ACC_W-1:0]   w_sum_sat;

    // Ready is a pure decode of the registered state; clear only gates the accept.
    assign in_ready = (r_state == S_ACCUM);
    assign w_accept = in_ready && in_valid && !clear;

    // Running sum with clamp at the top of the result range.
    assign w_sum     = SUM_W'(r_acc) + SUM_W'(product);
    assign w_sat     = (w_sum > SUM_W'(ACC_MAX));
    assign w_sum_sat = w_sat ? ACC_MAX : w_sum[ACC_W-1:0];

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_acc_out   <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sticky    <= w_sticky_nxt;
            r_acc_out   <= w_acc_out_nxt;
            r_overflow  <= w_overflow_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state and datapath update: clear beats accept and handshake.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_sticky_nxt    = r_sticky;
        w_acc_out_nxt   = r_acc_out;
        w_overflow_nxt  = r_overflow;
        w_out_valid_nxt = r_out_valid;

        if (clear) begin
            w_state_nxt     = S_ACCUM;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_sticky_nxt    = 1'b0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        if (r_cnt == CNT_LAST) begin
                            w_acc_out_nxt   = w_sum_sat;
                            w_overflow_nxt  = r_sticky | w_sat;
                            w_acc_nxt       = '0;
                            w_cnt_nxt       = '0;
                            w_sticky_nxt    = 1'b0;
                            w_out_valid_nxt = 1'b1;
                            w_state_nxt     = S_HOLD;
                        end else begin
                            w_acc_nxt    = {1'b0, w_sum_sat};
                            w_cnt_nxt    = r_cnt + CNT_W'(1);
                            w_sticky_nxt = r_sticky | w_sat;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = S_ACCUM;
                    end
                end
                default: begin
                    w_state_nxt = S_ACCUM;
                end
            endcase
        end
    end

    assign acc_out   = r_acc_out;
    assign overflow  = r_overflow;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default instance (ACC_W=19) and a
// narrow instance (ACC_W=16) share one input stream so saturation is visible.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] product;
    logic        clear;
    logic        out_ready;

    logic        in_ready;
    logic [18:0] acc_out;
    logic        out_valid;
    logic        overflow;

    logic        in_ready16;
    logic [15:0] acc_out16;
    logic        out_valid16;
    logic        overflow16;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    product_accumulator #(.N(8), .ACC_W(19)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .clear(clear), .acc_out(acc_out),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
    );

    product_accumulator #(.N(8), .ACC_W(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
        .product(product), .clear(clear), .acc_out(acc_out16),
        .out_valid(out_valid16), .out_ready(out_ready), .overflow(overflow16)
    );

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] p);
        in_valid = 1'b1;
        product  = p;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; product = '0; clear = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        vectors++;
        if ({out_valid, overflow, acc_out} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%0b ov=%0b acc=%0h, want 0/0/0", out_valid, overflow, acc_out);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %0b, want 1", in_ready);
        end
    endtask

    task automatic test_basic_group();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_accum_%0d: got rdy=%0b v=%0b, want 1/0", k, in_ready, out_valid);
            end
            accept(16'(k));
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || acc_out !== 19'd36 || overflow !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: got v=%0b acc=%0d ov=%0b rdy=%0b, want 1/36/0/0",
                     out_valid, acc_out, overflow, in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_release: got v=%0b rdy=%0b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_max_default();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) accept(16'hFFFF);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || acc_out !== 19'h7FFF8 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL max_default: got v=%0b acc=%0h ov=%0b, want 1/7fff8/0", out_valid, acc_out, overflow);
        end
        vectors++;
        if (out_valid16 !== 1'b1 || acc_out16 !== 16'hFFFF || overflow16 !== 1'b1) begin
            miscompares++;
            $display("FAIL max_narrow: got v=%0b acc=%0h ov=%0b, want 1/ffff/1", out_valid16, acc_out16, overflow16);
        end
        step();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        accept(16'hFFFF);
        for (int k = 0; k < 7; k++) accept(16'h0001);
        in_valid = 1'b0;
        vectors++;
        if (out_valid16 !== 1'b1 || acc_out16 !== 16'hFFFF || overflow16 !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_narrow: got v=%0b acc=%0h ov=%0b, want 1/ffff/1", out_valid16, acc_out16, overflow16);
        end
        vectors++;
        if (acc_out !== 19'h10006 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_wide: got acc=%0h ov=%0b, want 10006/0", acc_out, overflow);
        end
        step();
        for (int k = 0; k < 8; k++) accept(16'h0001);
        in_valid = 1'b0;
        vectors++;
        if (out_valid16 !== 1'b1 || acc_out16 !== 16'd8 || overflow16 !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_recover: got v=%0b acc=%0d ov=%0b, want 1/8/0", out_valid16, acc_out16, overflow16);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) accept(16'h0100);
        product = 16'h1234;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_out !== 19'h800) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: got rdy=%0b v=%0b acc=%0h, want 0/1/800", c, in_ready, out_valid, acc_out);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got v=%0b rdy=%0b, want 0/1", out_valid, in_ready);
        end
        accept(16'h1234);
        for (int k = 0; k < 7; k++) accept(16'h0001);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || acc_out !== 19'h123B) begin
            miscompares++;
            $display("FAIL bp_next_group: got v=%0b acc=%0h, want 1/123b", out_valid, acc_out);
        end
        step();
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) accept(16'h0010);
        clear = 1'b1;
        accept(16'h0010);
        clear = 1'b0;
        for (int k = 0; k < 7; k++) accept(16'h0002);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_count: got v=%0b after 7 post-clear accepts, want 0", out_valid);
        end
        accept(16'h0002);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || acc_out !== 19'd16 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_result: got v=%0b acc=%0d ov=%0b, want 1/16/0", out_valid, acc_out, overflow);
        end
        step();
        for (int k = 0; k < 7; k++) accept(16'h0005);
        clear = 1'b1;
        accept(16'h0005);
        clear = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_nth: got v=%0b rdy=%0b, want 0/1", out_valid, in_ready);
        end
        for (int k = 0; k < 8; k++) accept(16'h0004);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || acc_out !== 19'd32) begin
            miscompares++;
            $display("FAIL clear_fresh: got v=%0b acc=%0d, want 1/32", out_valid, acc_out);
        end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        accept(16'hFFFF);
        for (int k = 0; k < 7; k++) accept(16'h0001);
        in_valid = 1'b0;
        vectors++;
        if (out_valid16 !== 1'b1 || overflow16 !== 1'b1 || acc_out !== 19'h10006) begin
            miscompares++;
            $display("FAIL areset_pre: got v16=%0b ov16=%0b acc=%0h, want 1/1/10006", out_valid16, overflow16, acc_out);
        end
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || acc_out !== 19'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_wide: got v=%0b acc=%0h ov=%0b, want 0/0/0", out_valid, acc_out, overflow);
        end
        vectors++;
        if (out_valid16 !== 1'b0 || acc_out16 !== 16'd0 || overflow16 !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_narrow: got v=%0b acc=%0h ov=%0b, want 0/0/0", out_valid16, acc_out16, overflow16);
        end
        #2;
        reset = 1'b0;
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) accept(16'd3);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || acc_out !== 19'd24 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_after: got v=%0b acc=%0d ov=%0b, want 1/24/0", out_valid, acc_out, overflow);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_group();
        test_max_default();
        test_saturation();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
